// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types, result codes and sign helper for iter_comparator
package cmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef logic [1:0] res_t;

   localparam res_t RES_EQ = 2'd0;
   localparam res_t RES_LT = 2'd1;
   localparam res_t RES_GT = 2'd2;

   // Inverting the sign bit of both operands maps two's-complement order onto unsigned order.
   function automatic logic flip_msb(input logic msb, input logic signed_mode);
      return msb ^ signed_mode;
   endfunction

endpackage

// File: rtl/cmp_chunk.sv
// rtl/cmp_chunk.sv - combinational CHUNK-bit unsigned magnitude compare
module cmp_chunk #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   output logic             lt,
   output logic             gt
);

   assign lt = (x < y);
   assign gt = (x > y);

endmodule

// File: rtl/iter_comparator.sv
// rtl/iter_comparator.sv - multi-cycle MSB-first comparator; ITER_COMPARATOR_EARLY_EXIT_EN enables early exit
module iter_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             busy,
   output logic             done,
   output logic             equal,
   output logic             lower,
   output logic             greater
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [IDXW-1:0]  idx;
   res_t             pend;
   res_t             res_now;
   logic             accept;
   logic             finish;
   logic             chunk_lt;
   logic             chunk_gt;

   logic [CHUNK-1:0] ca [NCHUNK];
   logic [CHUNK-1:0] cb [NCHUNK];

   for (genvar g = 0; g < NCHUNK; g++) begin : g_slice
      assign ca[g] = opa[g*CHUNK +: CHUNK];
      assign cb[g] = opb[g*CHUNK +: CHUNK];
   end

   cmp_chunk #(
      .CHUNK(CHUNK)
   ) u_chunk (
      .x (ca[idx]),
      .y (cb[idx]),
      .lt(chunk_lt),
      .gt(chunk_gt)
   );

   // Only the most significant differing chunk decides; later chunks cannot override it.
   always_comb begin
      res_now = pend;
      if (pend == RES_EQ) begin
         if (chunk_lt) begin
            res_now = RES_LT;
         end else if (chunk_gt) begin
            res_now = RES_GT;
         end
      end
   end

   assign accept = start && (state != RUN);
   assign finish = (state == RUN) && (state_nx == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
`ifdef ITER_COMPARATOR_EARLY_EXIT_EN
            if ((idx == '0) || (res_now != RES_EQ)) begin
               state_nx = DONE;
            end
`else
            if (idx == '0) begin
               state_nx = DONE;
            end
`endif
         end
         DONE: begin
            done     = 1'b1;
            state_nx = start ? RUN : IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opa     <= '0;
         opb     <= '0;
         idx     <= '0;
         pend    <= RES_EQ;
         equal   <= 1'b0;
         lower   <= 1'b0;
         greater <= 1'b0;
      end else if (accept) begin
         opa            <= a;
         opb            <= b;
         opa[WIDTH-1]   <= flip_msb(a[WIDTH-1], signed_mode);
         opb[WIDTH-1]   <= flip_msb(b[WIDTH-1], signed_mode);
         idx            <= IDX_LAST;
         pend           <= RES_EQ;
      end else if (state == RUN) begin
         pend <= res_now;
         if (idx != '0) begin
            idx <= idx - 1'b1;
         end
         if (finish) begin
            equal   <= (res_now == RES_EQ);
            lower   <= (res_now == RES_LT);
            greater <= (res_now == RES_GT);
         end
      end
   end

endmodule

// File: tb/tb_iter_comparator.sv
// tb/tb_iter_comparator.sv - scoreboard bench for iter_comparator against an arithmetic reference model
module tb_iter_comparator;

   localparam int WIDTH  = 32;
   localparam int CHUNK  = 8;
   localparam int NCHUNK = WIDTH / CHUNK;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             signed_mode = 1'b0;
   logic             busy;
   logic             done;
   logic             equal;
   logic             lower;
   logic             greater;

   iter_comparator #(
      .WIDTH(WIDTH),
      .CHUNK(CHUNK)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a          (a),
      .b          (b),
      .signed_mode(signed_mode),
      .busy       (busy),
      .done       (done),
      .equal      (equal),
      .lower      (lower),
      .greater    (greater)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [2:0] flags;
      int         accept;
      int         lat;
   } exp_t;

   exp_t       q[$];
   exp_t       e;
   int         errors = 0;
   int         checks = 0;
   logic [2:0] last_flags = 3'b000;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // flags packed as {equal, lower, greater}
   function automatic logic [2:0] ref_flags(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                            input logic sm);
      logic lt;
      if (av == bv) return 3'b100;
      if (sm) lt = ($signed(av) < $signed(bv));
      else    lt = (av < bv);
      return lt ? 3'b010 : 3'b001;
   endfunction

   function automatic int ref_lat(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
`ifdef ITER_COMPARATOR_EARLY_EXIT_EN
      logic [WIDTH-1:0] x;
      int p;
      x = av ^ bv;
      if (x == '0) return NCHUNK;
      p = 0;
      for (int i = 0; i < WIDTH; i++) if (x[i]) p = i;
      return NCHUNK - (p / CHUNK);
`else
      return (av == bv) ? NCHUNK : NCHUNK;
`endif
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (done) begin
            if (q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               e = q.pop_front();
               check("flags", {equal, lower, greater}, e.flags);
               check("latency", cyc - e.accept, e.lat);
               last_flags = e.flags;
            end
         end else if (busy) begin
            check("hold_in_run", {equal, lower, greater}, last_flags);
         end
      end
   end

   // Called at a falling edge; returns at the falling edge after the accepting edge.
   task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic sm, input bit push);
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("issue_wait", busy, 0);
      a           = av;
      b           = bv;
      signed_mode = sm;
      start       = 1'b1;
      if (push) q.push_back('{ref_flags(av, bv, sm), cyc + 1, ref_lat(av, bv)});
      @(negedge clk);
      start       = 1'b0;
      a           = $urandom;
      b           = $urandom;
      signed_mode = 1'($urandom);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("wait_done", done, 1);
   endtask

   initial begin
      logic [WIDTH-1:0] av;
      logic [WIDTH-1:0] bv;
      int               n;

      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_flags", {equal, lower, greater}, 3'b000);
      rst = 1'b0;
      @(negedge clk);

      issue(32'd5, 32'd7, 1'b0, 1'b1);
      issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1);
      issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
      issue(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b1);
      issue(32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1);
      wait_done();
      @(negedge clk);

      // abort during the second RUN cycle
      issue(32'd1, 32'd2, 1'b0, 1'b0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_flags", {equal, lower, greater}, 3'b000);
      last_flags = 3'b000;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      issue(32'd1, 32'd2, 1'b0, 1'b1);

      // start while busy is dropped; start in DONE is taken
      issue(32'd3, 32'd3, 1'b0, 1'b1);
      a     = 32'd9;
      b     = 32'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      issue(32'd9, 32'd1, 1'b0, 1'b1);

      for (int i = 0; i < 40; i++) begin
         av = $urandom;
         case ($urandom_range(0, 3))
            0:       bv = av;
            1:       bv = av ^ (32'd1 << $urandom_range(0, CHUNK - 1));
            2:       bv = $urandom;
            default: bv = av ^ 32'h8000_0000;
         endcase
         issue(av, bv, 1'($urandom), 1'b1);
      end

      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain", q.size(), 0);
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
